// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding and funct3 load/store size codes for the MW-stage memory controller.
`default_nettype none
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/lsu_data_align.sv
// lsu_data_align: store lane replication / byte-enable generation and load byte/half select with extension.
`default_nettype none
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] load_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_raw[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
  end

  // Size comes from funct3[1:0] only, so signed and unsigned loads share lanes.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (funct3[1:0])
      F3_B[1:0]: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_H[1:0]: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_ext = rdata_raw;
    case (funct3)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_ext = {24'd0, byte_sel};
      F3_HU:   load_ext = {16'd0, half_sel};
      default: load_ext = rdata_raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: MW-stage data-memory access controller; drives the valid/ready bus, stalls the
// pipeline while an access is in flight, and returns aligned load data for one cycle in DONE.
`default_nettype none
module mem_stall_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        stallMW,
  output logic        misalign,
  output logic        bus_err
);

  localparam int             CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_CNT = CW'(TIMEOUT);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     cap_q, cap_d;

  logic            access;
  logic            op;
  logic            req_valid_w;
  logic            stall_w;
  logic            bus_err_w;
  logic [31:0]     load_ext;

  lsu_data_align u_align (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .rdata_raw  (rsp_rdata),
    .be         (req_be),
    .wdata_lane (req_wdata),
    .load_ext   (load_ext)
  );

  always_comb begin
    access   = mem_rd | mem_wr;
    misalign = access & (((funct3[1:0] == F3_H[1:0]) & addr[0]) |
                         ((funct3[1:0] == F3_W[1:0]) & (|addr[1:0])));
    op       = access & ~misalign;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    req_valid_w = 1'b0;
    stall_w     = 1'b0;
    bus_err_w   = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          req_valid_w = 1'b1;
          stall_w     = 1'b1;
          if (req_ready) begin
            state_d = WAIT_RSP;
            cnt_d   = '0;
          end
        end
      end
      WAIT_RSP: begin
        stall_w = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        // A response arriving on the timeout cycle still wins.
        if (rsp_valid) begin
          cap_d   = mem_rd ? load_ext : 32'd0;
          state_d = DONE;
        end else if (cnt_q == TO_CNT) begin
          bus_err_w = 1'b1;
          cap_d     = 32'd0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  // Gate with rst_n so an op sitting on the inputs during reset cannot raise a request or stall.
  always_comb begin
    req_valid = rst_n & req_valid_w;
    stall     = rst_n & stall_w;
    stallMW   = rst_n & stall_w;
    bus_err   = rst_n & bus_err_w;
    req_we    = mem_wr;
    req_addr  = {addr[31:2], 2'b00};
    rdata     = (state_q == DONE) ? cap_q : 32'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stall_ctrl.sv
// tb_mem_stall_ctrl: scoreboard bench for mem_stall_ctrl (TIMEOUT overridden to 4).
`default_nettype none
module tb_mem_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] rdata;
  logic        stall, stallMW, misalign, bus_err;

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   stall_cnt = 0;
  logic prev_stall = 1'b0;

  mem_stall_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rdata     (rdata),
    .stall     (stall),
    .stallMW   (stallMW),
    .misalign  (misalign),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Completion monitor: a falling stall marks DONE; pop the scoreboard there.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      if (stall) begin
        stall_cnt++;
      end else if (prev_stall) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_rdata", rdata, e.rdata);
          check("stall_len", 32'(stall_cnt), 32'(e.stalls));
          check("done_stallMW", {31'd0, stallMW}, 32'd0);
        end
        stall_cnt = 0;
      end
      prev_stall = stall;
    end
  end

  task automatic idle_inputs();
    mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'd0; wdata = 32'd0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'd0;
  endtask

  // Full handshake: ready after rdy_dly cycles, response rsp_dly cycles after the first WAIT cycle.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int rdy_dly, input int rsp_dly,
                       input logic [31:0] rsp, input logic [31:0] exp_rd,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    exp_t e;
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    e.rdata  = exp_rd;
    e.stalls = rdy_dly + 2 + rsp_dly;
    sb_q.push_back(e);
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i == rdy_dly) req_ready = 1'b1;
      @(negedge clk);
      check("req_valid", {31'd0, req_valid}, 32'd1);
      check("req_be", {28'd0, req_be}, {28'd0, exp_be});
      check("req_addr", req_addr, {a[31:2], 2'b00});
      check("req_we", {31'd0, req_we}, {31'd0, wr});
      if (wr) check("req_wdata", req_wdata, exp_wd);
      @(posedge clk); #1;
    end
    req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      @(negedge clk);
      check("wait_valid_low", {31'd0, req_valid}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_valid = 1'b1; rsp_rdata = rsp;
    @(negedge clk);
    check("wait_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check("done_no_reissue", {31'd0, req_valid}, 32'd0);
    check("done_no_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    logic got;
    exp_t e;

    idle_inputs();
    rst_n = 1'b0;
    mem_rd = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    mem_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // lw 0x100, immediate ready and response
    do_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'd0);
    // lb / lbu 0x103
    do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 0, 32'h80FF_FFFF, 32'hFFFF_FF80, 4'b1000, 32'd0);
    do_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 0, 0, 32'h80FF_FFFF, 32'h0000_0080, 4'b1000, 32'd0);
    // lh / lhu upper half, slow response
    do_op(1'b1, 1'b0, 3'b001, 32'h206, 32'd0, 1, 2, 32'h9ABC_1234, 32'hFFFF_9ABC, 4'b1100, 32'd0);
    do_op(1'b1, 1'b0, 3'b101, 32'h204, 32'd0, 0, 1, 32'h9ABC_8234, 32'h0000_8234, 4'b0011, 32'd0);
    // sh 0x102 with ready low 3 cycles; sb; sw
    do_op(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 3, 0, 32'hFFFF_FFFF, 32'd0, 4'b1100, 32'hABCDABCD);
    do_op(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_0057, 0, 0, 32'hFFFF_FFFF, 32'd0, 4'b0010, 32'h57575757);
    do_op(1'b0, 1'b1, 3'b010, 32'h308, 32'hCAFE_1234, 1, 0, 32'h0, 32'd0, 4'b1111, 32'hCAFE_1234);

    // misaligned lw: no request, no stall
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h101; rsp_valid = 1'b1; rsp_rdata = 32'h5555_5555;
    @(negedge clk);
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_req_valid", {31'd0, req_valid}, 32'd0);
    check("mis_stall", {31'd0, stall}, 32'd0);
    check("mis_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    mem_rd = 1'b0; rsp_valid = 1'b0;
    @(negedge clk);
    check("idle_rsp_ignored", rdata, 32'd0);
    @(posedge clk); #1;

    // timeout with no response
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h400; req_ready = 1'b1;
    e.rdata = 32'd0; e.stalls = 6; sb_q.push_back(e);
    @(posedge clk); #1;
    req_ready = 1'b0;
    waits = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus_err) got = 1'b1; else waits++;
      @(posedge clk); #1;
    end
    check("timeout_seen", {31'd0, got}, 32'd1);
    check("timeout_waits", 32'(waits), 32'd4);
    @(negedge clk);
    check("to_done_stall", {31'd0, stall}, 32'd0);
    check("to_err_pulse", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    mem_rd = 1'b0;

    // response on the timeout cycle wins
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h500; req_ready = 1'b1;
    e.rdata = 32'h1122_3344; e.stalls = 6; sb_q.push_back(e);
    @(posedge clk); #1;
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tw_no_err", {31'd0, bus_err}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_valid = 1'b1; rsp_rdata = 32'h1122_3344;
    @(negedge clk);
    check("tw_rsp_wins", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    mem_rd = 1'b0;

    // reset during WAIT_RSP, then a late response
    mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h600; req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_valid", {31'd0, req_valid}, 32'd0);
    mem_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("late_rsp_rdata", rdata, 32'd0);
    check("late_rsp_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check("post_rst_rdata", rdata, 32'd0);

    // operation after recovery
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 3'b010, 32'h700, 32'd0, 0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
